// File: rtl/nebula_walking_pkg.sv
// Shared types and constants for the walking-one GPIO sample block.
package nebula_walking_pkg;

  localparam int unsigned WIDTH_DEF   = 34;
  localparam int unsigned IO_BITS_DEF = 38;

  typedef enum logic [1:0] {
    StIdle,
    StZero,
    StWalk
  } state_e;

  // io[4:1] are left to the management SoC (SPI/UART), so they stay inputs.
  localparam logic [IO_BITS_DEF-1:0] ReservedMask = 38'h1E;

endpackage

// File: rtl/nebula_step_timer.sv
// Step timer: counts 0..StepCycles-1 while not cleared; tc_o marks the last cycle of a step.
module nebula_step_timer #(
  parameter int unsigned StepCycles = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(StepCycles + 1);

  logic [CntW-1:0] cnt_q;

  assign tc_o = !clr_i && (cnt_q == CntW'(StepCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i || tc_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/nebula_walking_gpio.sv
// Walking-one pattern generator on the Caravel user GPIOs {io[37:5], io[0]}.
module nebula_walking_gpio
  import nebula_walking_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned STEP_CYCLES = 1000,
  parameter int unsigned IO_BITS     = IO_BITS_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               en,
  input  logic [IO_BITS-1:0] io_in,
  output logic [IO_BITS-1:0] io_out,
  output logic [IO_BITS-1:0] io_oeb,
  output logic               sweep_done,
  output logic [7:0]         sweep_cnt
);

  state_e           state_q;
  logic [WIDTH-1:0] pattern_q;
  logic             sweep_done_q;
  logic [7:0]       sweep_cnt_q;
  logic             step_clr;
  logic             step_tc;
  logic             unused_io_in;

  assign unused_io_in = ^io_in;

  // Counter idles at zero so every ZERO step starts with a full STEP_CYCLES hold.
  assign step_clr = (state_q == StIdle) || !en;

  nebula_step_timer #(
    .StepCycles(STEP_CYCLES)
  ) u_step_timer (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .clr_i(step_clr),
    .tc_o (step_tc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= StIdle;
      pattern_q    <= '0;
      sweep_done_q <= 1'b0;
      sweep_cnt_q  <= '0;
    end else begin
      sweep_done_q <= 1'b0;
      if (!en) begin
        state_q   <= StIdle;
        pattern_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q   <= StZero;
            pattern_q <= '0;
          end
          StZero: begin
            if (step_tc) begin
              state_q   <= StWalk;
              pattern_q <= WIDTH'(1);
            end
          end
          StWalk: begin
            if (step_tc) begin
              if (pattern_q[WIDTH-1]) begin
                state_q      <= StZero;
                pattern_q    <= '0;
                sweep_done_q <= 1'b1;
                sweep_cnt_q  <= sweep_cnt_q + 8'd1;
              end else begin
                pattern_q <= pattern_q << 1;
              end
            end
          end
          default: begin
            state_q   <= StIdle;
            pattern_q <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    io_out                = '0;
    io_out[0]             = pattern_q[0];
    io_out[IO_BITS-1:5]   = pattern_q[WIDTH-1:1];
  end

  assign io_oeb     = ReservedMask;
  assign sweep_done = sweep_done_q;
  assign sweep_cnt  = sweep_cnt_q;

endmodule

// File: tb/tb_nebula_walking_gpio.sv
// Randomised scoreboard bench for nebula_walking_gpio with a time-indexed sweep model.
module tb_nebula_walking_gpio;

  localparam int S   = 4;
  localparam int W   = 34;
  localparam int IOB = 38;
  localparam int PER = (W + 1) * S;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic            en = 1'b0;
  logic [IOB-1:0]  io_in = '0;
  logic [IOB-1:0]  io_out;
  logic [IOB-1:0]  io_oeb;
  logic            sweep_done;
  logic [7:0]      sweep_cnt;

  typedef struct packed {
    logic [W-1:0] pat;
    logic         done;
    logic [7:0]   cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: a run is a count of cycles since the first ZERO cycle.
  bit           m_run = 1'b0;
  int           m_t   = 0;
  logic [7:0]   m_cnt = '0;
  logic [W-1:0] m_pat = '0;

  nebula_walking_gpio #(
    .WIDTH      (W),
    .STEP_CYCLES(S),
    .IO_BITS    (IOB)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .en        (en),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .sweep_done(sweep_done),
    .sweep_cnt (sweep_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [W-1:0] pat_at(input int t);
    int ph;
    logic [W-1:0] one;
    ph  = (t / S) % (W + 1);
    one = 1;
    return (ph == 0) ? '0 : (one << (ph - 1));
  endfunction

  task automatic cyc(input logic rst, input logic e);
    exp_t x;
    @(negedge wb_clk_i);
    wb_rst_i = rst;
    en       = e;
    io_in    = {$urandom, $urandom};
    x.done   = 1'b0;
    if (rst) begin
      m_run = 1'b0;
      m_t   = 0;
      m_cnt = '0;
    end else if (!e) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_t   = 0;
    end else begin
      m_t++;
      if (m_t % PER == 0) begin
        x.done = 1'b1;
        m_cnt  = m_cnt + 8'd1;
      end
    end
    m_pat = m_run ? pat_at(m_t) : '0;
    x.pat = m_pat;
    x.cnt = m_cnt;
    q.push_back(x);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge wb_clk_i) begin
    exp_t           e;
    logic [IOB-1:0] exp_io;
    logic [W-1:0]   got_pat;
    #1;
    if (q.size() > 0) begin
      e       = q.pop_front();
      exp_io  = {e.pat[W-1:1], 4'b0000, e.pat[0]};
      got_pat = {io_out[IOB-1:5], io_out[0]};
      check("io_out", 64'(io_out), 64'(exp_io));
      check("sweep_done", 64'(sweep_done), 64'(e.done));
      check("sweep_cnt", 64'(sweep_cnt), 64'(e.cnt));
      check("io_oeb", 64'(io_oeb), 64'(38'h1E));
      check("onehot0", 64'($onehot0(got_pat)), 64'(1));
    end
  end

  initial begin
    int g;
    repeat (3) cyc(1'b1, 1'b1);
    repeat (2 * PER + 3) cyc(1'b0, 1'b1);

    // Abort while bit 8 is lit, then restart.
    g = 0;
    while (m_pat != 34'h100 && g < 2000) begin
      cyc(1'b0, 1'b1);
      g++;
    end
    check("reach_bit8", 64'(m_pat), 64'(34'h100));
    cyc(1'b0, 1'b0);
    repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0);
    repeat (50) cyc(1'b0, 1'b1);

    // Reset mid-sweep while bit 15 is lit.
    g = 0;
    while (m_pat != 34'h8000 && g < 2000) begin
      cyc(1'b0, 1'b1);
      g++;
    end
    check("reach_bit15", 64'(m_pat), 64'(34'h8000));
    cyc(1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b1);

    repeat (400) cyc(1'b0, ($urandom_range(0, 15) != 0));

    // Counter wrap over 256 complete sweeps.
    cyc(1'b1, 1'b1);
    repeat (256 * PER + 10) cyc(1'b0, 1'b1);

    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
